// File: rtl/swap_cmd_pkg.sv
// Shared types and constants for the swap register command sequencer.
package swap_cmd_pkg;

    localparam int HCW     = 8;
    localparam int NUM_CMD = 3;

    localparam int CMD_SET1 = 0;
    localparam int CMD_SET2 = 1;
    localparam int CMD_SWAP = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef logic [NUM_CMD-1:0] cmd_vec_t;

    // Lowest index wins, so set1 > set2 > swap falls out of the bit order.
    function automatic cmd_vec_t pick_cmd(input cmd_vec_t cand);
        return cand & (~cand + cmd_vec_t'(1));
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchronizer followed by a rising-edge detector for one async level.
module sync_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic s1, s2, prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= d;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 & ~prev;

endmodule

// File: rtl/swap_cmd_seq.sv
// Synchronizes/edge-detects set1/set2/swap requests, arbitrates, and issues spaced one-cycle pulses.
// Define SWAP_CMD_SEQ_STATS_EN to add the saturating merge_cnt statistics output.
module swap_cmd_seq
    import swap_cmd_pkg::*;
#(
    parameter int HOLDOFF = 4,
    parameter int PERIOD  = 16,
    parameter int CW      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req1,
    input  logic       req2,
    input  logic       req_swap,
    input  logic       auto_en,
    output logic       set1,
    output logic       set2,
    output logic       swap,
    output logic       busy
`ifdef SWAP_CMD_SEQ_STATS_EN
    ,
    output logic [7:0] merge_cnt
`endif
);

    cmd_vec_t       req_v, rise, pend, pend_nxt, cand, auto_v, cmd_q, cmd_nxt;
    state_t         state, state_nxt;
    logic [HCW-1:0] hcnt, hcnt_nxt;
    logic [CW-1:0]  pcnt;
    logic           tc;

    assign req_v = {req_swap, req2, req1};

    for (genvar i = 0; i < NUM_CMD; i++) begin : g_sync
        sync_rise_det u_sync (
            .clk  (clk),
            .reset(reset),
            .d    (req_v[i]),
            .rise (rise[i])
        );
    end

    // Auto-swap period counter: cleared whenever disabled, wraps on terminal count.
    assign tc = auto_en && (pcnt == CW'(PERIOD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                pcnt <= '0;
        else if (!auto_en || tc)   pcnt <= '0;
        else                       pcnt <= pcnt + CW'(1);
    end

    always_comb begin
        auto_v           = '0;
        auto_v[CMD_SWAP] = tc;
    end

    assign cand     = pend | rise;
    assign pend_nxt = (pend | rise | auto_v) & ~cmd_nxt;

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        cmd_nxt   = '0;
        case (state)
            IDLE: begin
                if (|cand) begin
                    cmd_nxt   = pick_cmd(cand);
                    hcnt_nxt  = HCW'(HOLDOFF - 1);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (hcnt == '0) state_nxt = IDLE;
                else            hcnt_nxt  = hcnt - HCW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            hcnt  <= '0;
            pend  <= '0;
            cmd_q <= '0;
        end else begin
            state <= state_nxt;
            hcnt  <= hcnt_nxt;
            pend  <= pend_nxt;
            cmd_q <= cmd_nxt;
        end
    end

    assign set1 = cmd_q[CMD_SET1];
    assign set2 = cmd_q[CMD_SET2];
    assign swap = cmd_q[CMD_SWAP];
    assign busy = (state != IDLE) | (|pend);

`ifdef SWAP_CMD_SEQ_STATS_EN
    // A merge is any new event (edge or terminal count) landing on a flag already set.
    logic [2:0] merges;
    logic [8:0] msum;

    assign merges = 3'(rise[CMD_SET1] & pend[CMD_SET1])
                  + 3'(rise[CMD_SET2] & pend[CMD_SET2])
                  + 3'(rise[CMD_SWAP] & pend[CMD_SWAP])
                  + 3'(tc & pend[CMD_SWAP]);
    assign msum   = {1'b0, merge_cnt} + 9'(merges);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) merge_cnt <= '0;
        else        merge_cnt <= msum[8] ? 8'hff : msum[7:0];
    end
`endif

endmodule
